// File: rtl/tpu_pkg.sv
// Shared defaults, FSM state encoding and operand-generation functions for the
// systolic TPU demo.
package tpu_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tpu_state_e;

  // Fixed operand contents; callers truncate the result to their operand width.
  function automatic int a_init(input int i, input int k, input int n = N_DEF);
    return n * i + k + 1;
  endfunction

  function automatic int b_init(input int k, input int j);
    return k + j;
  endfunction

endpackage

// File: rtl/tpu_pe.sv
// One output-stationary processing element: multiply-accumulate plus
// registered pass-through of both operands to the neighbouring PEs.
module tpu_pe
  import tpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod_s;
  logic signed [AW-1:0]   prod_ext_s;

  assign prod_s     = $signed(a_in) * $signed(b_in);
  // Size cast of a signed value sign-extends the full-width product.
  assign prod_ext_s = AW'(prod_s);

  // Operand pipeline and accumulator; accumulation wraps modulo 2^AW.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (en) begin
        acc <= acc + prod_ext_s;
      end else begin
        acc <= acc;
      end
    end
  end

endmodule

// File: rtl/systolic_tpu_top.sv
// NxN output-stationary systolic matrix multiply C = A x B with skewed edge feed.
// Optional macro TPU_CYCLE_COUNT_EN adds a 16-bit RUN-cycle counter output.
module systolic_tpu_top
  import tpu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 done,
  input  logic [$clog2(N)-1:0] rd_row,
  input  logic [$clog2(N)-1:0] rd_col,
`ifdef TPU_CYCLE_COUNT_EN
  output logic [15:0]          cycle_count,
`endif
  output logic [AW-1:0]        rd_data
);

  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

  tpu_state_e    state_r;
  logic [TW-1:0] t_r;
  logic          done_r;
  logic          run_s;

  logic [DW-1:0] a_edge_s [N];
  logic [DW-1:0] b_edge_s [N];
  logic [DW-1:0] a_h_s [N][N+1];
  logic [DW-1:0] b_v_s [N+1][N];
  logic [AW-1:0] acc_s [N][N];

  assign run_s = (state_r == RUN);
  assign done  = done_r;

  // Run sequencer: one IDLE edge, then 3N-2 RUN steps, then DONE until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      t_r     <= '0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= RUN;
          t_r     <= '0;
          done_r  <= 1'b0;
        end
        RUN: begin
          t_r <= t_r + 1'b1;
          if (t_r == T_LAST) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= DONE;
          t_r     <= t_r;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          t_r     <= '0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_feed
    // Skewed feed: row gi / column gi lag the array corner by gi steps.
    always_comb begin
      a_edge_s[gi] = '0;
      b_edge_s[gi] = '0;
      if (run_s && (int'(t_r) >= gi) && (int'(t_r) - gi < N)) begin
        a_edge_s[gi] = DW'(a_init(gi, int'(t_r) - gi, N));
        b_edge_s[gi] = DW'(b_init(int'(t_r) - gi, gi));
      end else begin
        a_edge_s[gi] = '0;
        b_edge_s[gi] = '0;
      end
    end

    assign a_h_s[gi][0] = a_edge_s[gi];
    assign b_v_s[0][gi] = b_edge_s[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      tpu_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clock (clock),
        .reset (reset),
        .en    (run_s),
        .a_in  (a_h_s[gi][gj]),
        .b_in  (b_v_s[gi][gj]),
        .a_out (a_h_s[gi][gj+1]),
        .b_out (b_v_s[gi+1][gj]),
        .acc   (acc_s[gi][gj])
      );
    end
  end

  // Result read mux straight off the accumulators; shows partial sums mid-run.
  always_comb begin
    rd_data = '0;
    if ((int'(rd_row) < N) && (int'(rd_col) < N)) begin
      rd_data = acc_s[rd_row][rd_col];
    end else begin
      rd_data = '0;
    end
  end

`ifdef TPU_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_r;

  // Counts RUN edges only, so it freezes at 3N-2 once DONE is reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r <= 16'd0;
    end else if (run_s) begin
      cycle_cnt_r <= cycle_cnt_r + 16'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign cycle_count = cycle_cnt_r;
`endif

endmodule

// File: tb/tb_systolic_tpu_top.sv
// Directed self-checking bench for systolic_tpu_top (N=4, DW=8, AW=32).
// Checks cycle_count too when built with TPU_CYCLE_COUNT_EN.
module tb_systolic_tpu_top;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic          clock;
  logic          reset;
  logic          done;
  logic [1:0]    rd_row;
  logic [1:0]    rd_col;
  logic [AW-1:0] rd_data;
`ifdef TPU_CYCLE_COUNT_EN
  logic [15:0]   cycle_count;
`endif

  int vectors;
  int miscompares;

  systolic_tpu_top #(.N(N), .DW(DW), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .done        (done),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
`ifdef TPU_CYCLE_COUNT_EN
    .cycle_count (cycle_count),
`endif
    .rd_data     (rd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [AW-1:0] model_c(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) begin
      s = s + (4 * i + k + 1) * (k + j);
    end
    return AW'(s);
  endfunction

  // While reset is low every result reads 0 and done is low.
  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        rd_row = 2'(i);
        rd_col = 2'(j);
        #1;
        vectors++;
        if (rd_data !== 32'd0) begin
          miscompares++;
          $display("FAIL reset_rd(%0d,%0d): got %0d expected 0", i, j, rd_data);
        end
      end
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
  endtask

  // Release reset, watch done edge-by-edge, partial sums at edges 2 and 5.
  task automatic test_run();
    rd_row = 2'd0;
    rd_col = 2'd0;
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (done !== (e >= 11)) begin
        miscompares++;
        $display("FAIL done_edge%0d: got %b expected %b", e, done, (e >= 11));
      end
      if (e == 2) begin
        vectors++;
        if (rd_data !== 32'd0) begin
          miscompares++;
          $display("FAIL partial_e2: got %0d expected 0", rd_data);
        end
      end
      if (e == 5) begin
        vectors++;
        if (rd_data !== 32'd20) begin
          miscompares++;
          $display("FAIL partial_e5: got %0d expected 20", rd_data);
        end
      end
    end
`ifdef TPU_CYCLE_COUNT_EN
    vectors++;
    if (cycle_count !== 16'd10) begin
      miscompares++;
      $display("FAIL cycle_count_done: got %0d expected 10", cycle_count);
    end
`endif
    repeat (5) @(negedge clock);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_sticky: got %b expected 1", done);
    end
`ifdef TPU_CYCLE_COUNT_EN
    vectors++;
    if (cycle_count !== 16'd10) begin
      miscompares++;
      $display("FAIL cycle_count_frozen: got %0d expected 10", cycle_count);
    end
`endif
  endtask

  // Hand-computed corners, then all 16 entries against the software model.
  task automatic test_results();
    rd_row = 2'd0; rd_col = 2'd0; #1;
    vectors++;
    if (rd_data !== 32'd20) begin
      miscompares++;
      $display("FAIL c00: got %0d expected 20", rd_data);
    end
    rd_row = 2'd0; rd_col = 2'd1; #1;
    vectors++;
    if (rd_data !== 32'd30) begin
      miscompares++;
      $display("FAIL c01: got %0d expected 30", rd_data);
    end
    rd_row = 2'd1; rd_col = 2'd0; #1;
    vectors++;
    if (rd_data !== 32'd44) begin
      miscompares++;
      $display("FAIL c10: got %0d expected 44", rd_data);
    end
    rd_row = 2'd3; rd_col = 2'd3; #1;
    vectors++;
    if (rd_data !== 32'd266) begin
      miscompares++;
      $display("FAIL c33: got %0d expected 266", rd_data);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        rd_row = 2'(i);
        rd_col = 2'(j);
        #1;
        vectors++;
        if (rd_data !== model_c(i, j)) begin
          miscompares++;
          $display("FAIL c(%0d,%0d): got %0d expected %0d", i, j, rd_data, model_c(i, j));
        end
      end
    end
  endtask

  // Abort at edge 5 of a fresh run, check immediate clear, then rerun fully.
  task automatic test_midrun_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_done: got %b expected 0", done);
    end
`ifdef TPU_CYCLE_COUNT_EN
    vectors++;
    if (cycle_count !== 16'd0) begin
      miscompares++;
      $display("FAIL abort_cycle_count: got %0d expected 0", cycle_count);
    end
`endif
    test_reset();
    test_run();
    test_results();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    rd_row      = 2'd0;
    rd_col      = 2'd0;
    #2;
    test_reset();
    #15;
    test_run();
    test_results();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
